// File: rtl/id_ex_stage_pkg.sv
// Shared types and widths for the ID/EX pipeline register.
// Control bundle layout and the bubble value live here.
package id_ex_stage_pkg;

  localparam int ALUOP_W = 4;
  localparam int REG_W   = 5;

  typedef struct packed {
    logic               branch;
    logic               uncond_jmp;
    logic               memread;
    logic               memtoreg;
    logic               memwrite;
    logic               alusrc;
    logic               regwrite;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    UPD_LOAD,
    UPD_HOLD,
    UPD_FLUSH,
    UPD_STALL
  } upd_e;

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Load-use detector: decode consumer vs. load sitting in EX.
// Operand use is conservative; unknown encodings may stall.
module id_ex_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic             IF_ID_valid,
  input  logic             ID_unconditional_jmp,
  input  logic             ID_alusrc,
  input  logic             ID_memwrite,
  input  logic [REG_W-1:0] ID_rs1,
  input  logic [REG_W-1:0] ID_rs2,
  input  logic             ID_EX_valid,
  input  logic             ID_EX_memread,
  input  logic [REG_W-1:0] ID_EX_rd,
  output logic             load_use
);

  logic uses_rs1;
  logic uses_rs2;
  logic hit_rs1;
  logic hit_rs2;
  logic ld_in_ex;

  assign uses_rs1 = !ID_unconditional_jmp;
  assign uses_rs2 = (!ID_alusrc && !ID_unconditional_jmp)
                 || ID_memwrite;

  assign ld_in_ex = ID_EX_valid && ID_EX_memread
                 && (ID_EX_rd != '0);

  assign hit_rs1 = uses_rs1 && (ID_EX_rd == ID_rs1);
  assign hit_rs2 = uses_rs2 && (ID_EX_rd == ID_rs2);

  assign load_use = IF_ID_valid && ld_in_ex
                 && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion,
// EX flush, downstream hold and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IF_ID_valid,
  input  logic               ID_branch,
  input  logic               ID_unconditional_jmp,
  input  logic               ID_memread,
  input  logic               ID_memtoreg,
  input  logic               ID_memwrite,
  input  logic               ID_alusrc,
  input  logic               ID_regwrite,
  input  logic [ALUOP_W-1:0] ID_aluop,
  input  logic [DATA_W-1:0]  ID_imme,
  input  logic [DATA_W-1:0]  ID_pc,
  input  logic [DATA_W-1:0]  ID_rs1_data,
  input  logic [DATA_W-1:0]  ID_rs2_data,
  input  logic [REG_W-1:0]   ID_rs1,
  input  logic [REG_W-1:0]   ID_rs2,
  input  logic [REG_W-1:0]   ID_rd,
  input  logic               EX_flush,
  input  logic               hold_in,
  output logic               ID_EX_valid,
  output logic               ID_EX_branch,
  output logic               ID_EX_unconditional_jmp,
  output logic               ID_EX_memread,
  output logic               ID_EX_memtoreg,
  output logic               ID_EX_memwrite,
  output logic               ID_EX_alusrc,
  output logic               ID_EX_regwrite,
  output logic [ALUOP_W-1:0] ID_EX_aluop,
  output logic [DATA_W-1:0]  ID_EX_imme,
  output logic [DATA_W-1:0]  ID_EX_pc,
  output logic [DATA_W-1:0]  ID_EX_rs1_data,
  output logic [DATA_W-1:0]  ID_EX_rs2_data,
  output logic [REG_W-1:0]   ID_EX_rs1,
  output logic [REG_W-1:0]   ID_EX_rs2,
  output logic [REG_W-1:0]   ID_EX_rd,
  output logic               ID_stall,
  output logic [CNT_W-1:0]   bubble_count
);

  logic  load_use;
  logic  take;
  upd_e  upd;
  ctrl_t ctrl_in;
  ctrl_t ctrl_q;

  id_ex_hazard_detect u_hazard (
    .IF_ID_valid          (IF_ID_valid),
    .ID_unconditional_jmp (ID_unconditional_jmp),
    .ID_alusrc            (ID_alusrc),
    .ID_memwrite          (ID_memwrite),
    .ID_rs1               (ID_rs1),
    .ID_rs2               (ID_rs2),
    .ID_EX_valid          (ID_EX_valid),
    .ID_EX_memread        (ID_EX_memread),
    .ID_EX_rd             (ID_EX_rd),
    .load_use             (load_use)
  );

  // A flush already kills the consumer, so no extra stall.
  assign ID_stall = hold_in || (load_use && !EX_flush);

  always_comb begin
    upd = UPD_LOAD;
    if (hold_in)       upd = UPD_HOLD;
    else if (EX_flush) upd = UPD_FLUSH;
    else if (load_use) upd = UPD_STALL;
  end

  assign take = (upd == UPD_LOAD) && IF_ID_valid;

  assign ctrl_in = '{
    branch:     ID_branch,
    uncond_jmp: ID_unconditional_jmp,
    memread:    ID_memread,
    memtoreg:   ID_memtoreg,
    memwrite:   ID_memwrite,
    alusrc:     ID_alusrc,
    regwrite:   ID_regwrite,
    aluop:      ID_aluop
  };

  always_ff @(posedge clk) begin
    if (rst) begin
      ID_EX_valid    <= 1'b0;
      ctrl_q         <= CTRL_BUBBLE;
      ID_EX_imme     <= '0;
      ID_EX_pc       <= '0;
      ID_EX_rs1_data <= '0;
      ID_EX_rs2_data <= '0;
      ID_EX_rs1      <= '0;
      ID_EX_rs2      <= '0;
      ID_EX_rd       <= '0;
      bubble_count   <= '0;
    end else if (upd != UPD_HOLD) begin
      ID_EX_valid    <= take;
      ctrl_q         <= take ? ctrl_in     : CTRL_BUBBLE;
      ID_EX_imme     <= take ? ID_imme     : '0;
      ID_EX_pc       <= take ? ID_pc       : '0;
      ID_EX_rs1_data <= take ? ID_rs1_data : '0;
      ID_EX_rs2_data <= take ? ID_rs2_data : '0;
      ID_EX_rs1      <= take ? ID_rs1      : '0;
      ID_EX_rs2      <= take ? ID_rs2      : '0;
      ID_EX_rd       <= take ? ID_rd       : '0;
      if ((upd == UPD_STALL) && (bubble_count != '1))
        bubble_count <= bubble_count + 1'b1;
    end
  end

  assign ID_EX_branch            = ctrl_q.branch;
  assign ID_EX_unconditional_jmp = ctrl_q.uncond_jmp;
  assign ID_EX_memread           = ctrl_q.memread;
  assign ID_EX_memtoreg          = ctrl_q.memtoreg;
  assign ID_EX_memwrite          = ctrl_q.memwrite;
  assign ID_EX_alusrc            = ctrl_q.alusrc;
  assign ID_EX_regwrite          = ctrl_q.regwrite;
  assign ID_EX_aluop             = ctrl_q.aluop;

endmodule
